apb_cmd_master: RTL and testbench



---
 rtl/apb_cmd_master.sv | 167 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// APB3 requester: converts a valid/ready command stream into single APB transfers
// and reports read data, slave error and timeout on a valid/ready response channel.
`timescale 1ns/1ps
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] APB_M_0_paddr,
  output logic              APB_M_0_psel,
  output logic              APB_M_0_penable,
  output logic              APB_M_0_pwrite,
  output logic [DATA_W-1:0] APB_M_0_pwdata,
  input  logic [DATA_W-1:0] APB_M_0_prdata,
  input  logic              APB_M_0_pready,
  input  logic              APB_M_0_pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
  logic              r_pwrite, w_pwrite_nxt;
  logic              r_psel, w_psel_nxt;
  logic              r_penable, w_penable_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic              r_rsp_timeout, w_rsp_timeout_nxt;

  // Decoded from state only, so a held cmd_valid never loops back into cmd_ready.
  assign cmd_ready = (r_state == ST_IDLE) && !rst;

  // Next-state and next-output logic; APB strobes are computed for the state being entered.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_pwrite_nxt      = r_pwrite;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_paddr_nxt   = cmd_addr;
          w_pwdata_nxt  = cmd_wdata;
          w_pwrite_nxt  = cmd_write;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = ST_SETUP;
        end else begin
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
        end
      end
      ST_SETUP: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = {CNT_W{1'b0}};
        w_state_nxt   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready takes priority over an expiring timeout in the same cycle.
        if (APB_M_0_pready) begin
          w_rsp_rdata_nxt   = r_pwrite ? {DATA_W{1'b0}} : APB_M_0_prdata;
          w_rsp_err_nxt     = APB_M_0_pslverr;
          w_rsp_timeout_nxt = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_state_nxt       = ST_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_rsp_rdata_nxt   = {DATA_W{1'b0}};
          w_rsp_err_nxt     = 1'b1;
          w_rsp_timeout_nxt = 1'b1;
          w_rsp_valid_nxt   = 1'b1;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_state_nxt       = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_rsp_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset that abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= {CNT_W{1'b0}};
      r_paddr       <= {ADDR_W{1'b0}};
      r_pwdata      <= {DATA_W{1'b0}};
      r_pwrite      <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= {DATA_W{1'b0}};
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  assign APB_M_0_paddr   = r_paddr;
  assign APB_M_0_pwdata  = r_pwdata;
  assign APB_M_0_pwrite  = r_pwrite;
  assign APB_M_0_psel    = r_psel;
  assign APB_M_0_penable = r_penable;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_rdata       = r_rsp_rdata;
  assign rsp_err         = r_rsp_err;
  assign rsp_timeout     = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed table-driven bench for apb_cmd_master with a small APB slave model
// (programmable wait states, error, stuck-low and forced-high pready).
`timescale 1ns/1ps
module tb_apb_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .APB_M_0_paddr(paddr), .APB_M_0_psel(psel), .APB_M_0_penable(penable),
    .APB_M_0_pwrite(pwrite), .APB_M_0_pwdata(pwdata), .APB_M_0_prdata(prdata),
    .APB_M_0_pready(pready), .APB_M_0_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Slave model: pready after slv_waits extra ACCESS cycles, 16-word memory.
  int          slv_waits = 0;
  logic        slv_err   = 1'b0;
  logic        slv_stuck = 1'b0;
  logic        slv_force = 1'b0;
  logic        mem_clr   = 1'b1;
  int          acc_cnt;
  logic [31:0] mem [16];

  assign pready  = slv_force | (psel & penable & !slv_stuck & (acc_cnt == slv_waits));
  assign pslverr = slv_err & pready;
  assign prdata  = mem[paddr[5:2]];

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (psel && penable && pready && pwrite && !slv_err) begin
      mem[paddr[5:2]] <= pwdata;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic        stuck;
    logic        force_rdy;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called right after the accept edge: checks SETUP, then ACCESS until rsp_valid.
  task automatic finish_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic ok);
    lat = 1;
    ok  = (psel === 1'b1) && (penable === 1'b0) && (paddr === addr) &&
          (pwrite === wr) && (!wr || pwdata === wdata);
    while (rsp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid !== 1'b1)
        ok &= (psel === 1'b1) && (penable === 1'b1) && (paddr === addr) &&
              (pwrite === wr) && (!wr || pwdata === wdata);
    end
    ok &= (psel === 1'b0) && (penable === 1'b0);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic ok);
    int g;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    finish_cmd(wr, addr, wdata, lat, ok);
  endtask

  task automatic drain();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_drop", {31'h0, rsp_valid}, 32'h0);
    chk("ready_after_rsp", {31'h0, cmd_ready}, 32'h1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    logic ok;
    slv_waits = v.waits; slv_err = v.slverr; slv_stuck = v.stuck; slv_force = v.force_rdy;
    issue(v.wr, v.addr, v.wdata, lat, ok);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_apb_phases", idx), {31'h0, ok}, 32'h1);
    chk($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), {31'h0, rsp_err}, {31'h0, v.exp_err});
    chk($sformatf("v%0d_timeout", idx), {31'h0, rsp_timeout}, {31'h0, v.exp_to});
    drain();
    slv_force = 1'b0; slv_stuck = 1'b0; slv_err = 1'b0;
  endtask

  initial begin
    int   lat;
    logic ok;
    int   seen;

    //          wr    addr    wdata         wt  err   stuck force exp_rdata    err   to   lat
    vecs[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 1,  1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 4};
    vecs[1]  = '{1'b0, 32'h08, 32'h0,        0,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF,1'b0, 1'b0, 3};
    vecs[2]  = '{1'b1, 32'h04, 32'h00000001, 0,  1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 3};
    vecs[3]  = '{1'b0, 32'h04, 32'h0,        3,  1'b0, 1'b0, 1'b0, 32'h00000001,1'b0, 1'b0, 6};
    vecs[4]  = '{1'b1, 32'h24, 32'hCAFEF00D, 0,  1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 3};
    vecs[5]  = '{1'b0, 32'h10, 32'h0,        0,  1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 18};
    vecs[6]  = '{1'b0, 32'h08, 32'h0,        0,  1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 18};
    vecs[7]  = '{1'b0, 32'h08, 32'h0,        15, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF,1'b0, 1'b0, 18};
    vecs[8]  = '{1'b0, 32'h04, 32'h0,        2,  1'b1, 1'b0, 1'b0, 32'h00000001,1'b1, 1'b0, 5};
    vecs[9]  = '{1'b0, 32'h08, 32'h0,        0,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF,1'b0, 1'b0, 3};
    vecs[10] = '{1'b1, 32'h0C, 32'h12345678, 0,  1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 3};
    vecs[11] = '{1'b0, 32'h0C, 32'h0,        2,  1'b0, 1'b0, 1'b0, 32'h12345678,1'b0, 1'b0, 5};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_strobes", {24'h0, psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, 2'b00}, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    chk("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Response backpressure with a second command waiting.
    slv_waits = 0;
    issue(1'b0, 32'h08, 32'h0, lat, ok);
    chk("bp_first_lat", lat, 3);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'hA5A5A5A5;
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      ok &= (cmd_ready === 1'b0) && (psel === 1'b0) && (rsp_valid === 1'b1) &&
            (rsp_rdata === 32'hDEADBEEF) && (rsp_err === 1'b0) && (rsp_timeout === 1'b0);
    end
    chk("bp_hold_stable", {31'h0, ok}, 32'h1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_ready_after", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    finish_cmd(1'b1, 32'h30, 32'hA5A5A5A5, lat, ok);
    chk("bp_second_lat", lat, 3);
    chk("bp_second_phases", {31'h0, ok}, 32'h1);
    drain();

    // Reset while in ACCESS.
    slv_stuck = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rr_in_access", {30'h0, psel, penable}, 32'h3);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rr_abort", {29'h0, psel, penable, rsp_valid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rr_idle", {31'h0, cmd_ready}, 32'h1);
    slv_stuck = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1 || psel === 1'b1) seen++;
    end
    chk("rr_no_response", seen, 0);
    issue(1'b0, 32'h08, 32'h0, lat, ok);
    chk("rr_new_lat", lat, 3);
    chk("rr_new_rdata", rsp_rdata, 32'hDEADBEEF);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
